// File: rtl/apb_regbank.sv
// APB3 slave register bank: RW config words, RO status words, CTRL and sticky IRQ status.
// Define APB_REGBANK_WAIT_EN to insert WAIT_CYCLES wait states per access.
module apb_regbank #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned N_RW        = 4,
  parameter int unsigned N_RO        = 2,
  parameter int unsigned N_IRQ       = 2,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                I_PCLK,
  input  logic                I_PRESET,
  input  logic                I_PSEL,
  input  logic                I_PENABLE,
  input  logic                I_PWRITE,
  input  logic [ADDR_W-1:0]   I_PADDR,
  input  logic [31:0]         I_PWDATA,
  output logic [31:0]         O_PRDATA,
  output logic                O_PREADY,
  output logic                O_PSLVERR,
  output logic [N_RW*32-1:0]  O_RW_REGS,
  input  logic [N_RO*32-1:0]  I_RO_DATA,
  input  logic [N_IRQ-1:0]    I_IRQ_EVT,
  output logic                O_CTRL_START,
  output logic                O_CTRL_RESET,
  output logic                O_IRQ
);

  localparam int unsigned CtrlIdx  = N_RW + N_RO;
  localparam int unsigned IstatIdx = CtrlIdx + 1;

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e                   state_q, state_d;
  logic [N_RW-1:0][31:0]    rw_q, rw_d;
  logic                     irq_en_q, irq_en_d;
  logic [N_IRQ-1:0]         istat_q, istat_d, istat_clr;
  logic                     start_q, start_d;
  logic                     soft_rst_q, soft_rst_d;
  logic                     irq_q, irq_d;

  logic [31:0] word_idx;
  logic        wait_done;
  logic        pready;
  logic        ro_hit;
  logic        err;
  logic        commit;
  logic [31:0] rdata;

  assign word_idx = 32'(I_PADDR[ADDR_W-1:2]);

`ifdef APB_REGBANK_WAIT_EN
  logic [3:0] wcnt_q, wcnt_d;

  assign wait_done = (wcnt_q == 4'd0);

  always_comb begin
    wcnt_d = wcnt_q;
    if (state_q == StIdle) begin
      if (I_PSEL && !I_PENABLE) begin
        wcnt_d = 4'(WAIT_CYCLES);
      end
    end else if (wcnt_q != 4'd0) begin
      wcnt_d = wcnt_q - 4'd1;
    end
  end

  always_ff @(posedge I_PCLK) begin
    if (I_PRESET) begin
      wcnt_q <= 4'd0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end
`else
  logic unused_wait_cfg;
  assign unused_wait_cfg = |WAIT_CYCLES;
  assign wait_done       = 1'b1;
`endif

  // Reset masks completion so a transfer caught by reset can never commit.
  assign pready = (state_q == StAccess) && wait_done && I_PSEL && I_PENABLE && !I_PRESET;

  always_comb begin
    ro_hit = (word_idx >= N_RW) && (word_idx < N_RW + N_RO);
    err    = (I_PADDR[1:0] != 2'b00) || (word_idx >= N_RW + N_RO + 2) || (I_PWRITE && ro_hit);
  end

  assign commit = pready && I_PWRITE && !err;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (I_PSEL && !I_PENABLE) state_d = StAccess;
      StAccess: if (pready || !I_PSEL) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < N_RW; i++) begin
      if (word_idx == i) rdata = rw_q[i];
    end
    for (int unsigned i = 0; i < N_RO; i++) begin
      if (word_idx == N_RW + i) rdata = I_RO_DATA[32*i +: 32];
    end
    if (word_idx == CtrlIdx) rdata[2] = irq_en_q;
    if (word_idx == IstatIdx) rdata[N_IRQ-1:0] = istat_q;
  end

  always_comb begin
    rw_d       = rw_q;
    irq_en_d   = irq_en_q;
    istat_clr  = '0;
    start_d    = 1'b0;
    soft_rst_d = 1'b0;
    if (commit) begin
      for (int unsigned i = 0; i < N_RW; i++) begin
        if (word_idx == i) rw_d[i] = I_PWDATA;
      end
      if (word_idx == CtrlIdx) begin
        start_d    = I_PWDATA[0];
        soft_rst_d = I_PWDATA[1];
        irq_en_d   = I_PWDATA[2];
      end
      if (word_idx == IstatIdx) istat_clr = I_PWDATA[N_IRQ-1:0];
    end
    // OR-ing events after the clear lets a same-cycle event win.
    istat_d = (istat_q & ~istat_clr) | I_IRQ_EVT;
    irq_d   = (|istat_q) && irq_en_q;
  end

  always_ff @(posedge I_PCLK) begin
    if (I_PRESET) begin
      state_q    <= StIdle;
      rw_q       <= '0;
      irq_en_q   <= 1'b0;
      istat_q    <= '0;
      start_q    <= 1'b0;
      soft_rst_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      irq_en_q   <= irq_en_d;
      istat_q    <= istat_d;
      start_q    <= start_d;
      soft_rst_q <= soft_rst_d;
      irq_q      <= irq_d;
    end
  end

  assign O_PREADY     = pready;
  assign O_PSLVERR    = pready && err;
  assign O_PRDATA     = (pready && !I_PWRITE && !err) ? rdata : 32'd0;
  assign O_RW_REGS    = rw_q;
  assign O_CTRL_START = start_q;
  assign O_CTRL_RESET = soft_rst_q;
  assign O_IRQ        = irq_q;

endmodule
